// File: rtl/sha256_pad_if.sv
`default_nettype none
// ============================================================================
//  Module      : user_type (package) / sha256_pad_if (interface)
//  Description : Block type handed to the SHA-256 compression core, and the
//                byte-stream-in / block-out bundle of the message padder.
//  Revision    : 1.0  initial release
// ============================================================================

package user_type;
  // One 512-bit block plus framing; state mirrors the block-valid strobe.
  typedef struct packed {
    logic         state;
    logic         start;
    logic         stop;
    logic [511:0] w;
  } sha256in_t;
endpackage

interface sha256_pad_if #(
  parameter int IN_BYTES = 4,
  parameter int NB_W     = $clog2(IN_BYTES + 1)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*IN_BYTES-1:0] in_data;
  logic                  in_last;
  logic [NB_W-1:0]       in_nbytes;
  user_type::sha256in_t  out;
  logic                  out_valid;
  logic                  out_ready;

  // Message source / block sink side.
  modport master (
    output in_valid, in_data, in_last, in_nbytes, out_ready,
    input  in_ready, out, out_valid
  );

  // Padder side.
  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, out_ready,
    output in_ready, out, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/sha256_pad.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pad
//  Description : Streaming SHA-256 message padder. Packs IN_BYTES-wide beats
//                into 512-bit blocks and appends 0x80, zero fill and the
//                64-bit big-endian message bit length.
//  Revision    : 1.0  initial release
// ============================================================================

module sha256_pad #(
  parameter int IN_BYTES = 4,
  parameter int NB_W     = $clog2(IN_BYTES + 1)
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  sha256_pad_if.slave   bus
);

  localparam logic [1:0] S_FILL  = 2'd0;  // accepting message beats
  localparam logic [1:0] S_PAD2  = 2'd1;  // owe a length-only block
  localparam logic [1:0] S_PAD80 = 2'd2;  // owe a 0x80 + length block

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [511:0]          r_buf;
  logic [511:0]          r_w;
  logic [5:0]            r_ptr;
  logic [60:0]           r_len;
  logic                  r_first;
  logic                  r_start;
  logic                  r_stop;
  logic                  r_out_valid;

  logic                  w_acc;
  logic                  w_pad_load;
  logic                  w_wrap;
  logic [NB_W-1:0]       w_n;
  logic [6:0]            w_p;
  logic [8*IN_BYTES-1:0] w_beat;
  logic [511:0]          w_merged;
  logic [511:0]          w_tail;
  logic [511:0]          w_pad;
  logic [60:0]           w_len_nxt;

  // Beat accepted only in FILL with no block waiting for the sink.
  assign w_acc      = bus.in_valid && (r_state == S_FILL) && !r_out_valid;
  // A trailing pad block is loaded once the previous block has left.
  assign w_pad_load = (r_state != S_FILL) && !r_out_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  // Next state: a last beat whose 0x80 lands past byte 55 owes one more block.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_acc && bus.in_last) begin
          if (w_p == 7'd64)       w_state_nxt = S_PAD80;
          else if (w_p >= 7'd56)  w_state_nxt = S_PAD2;
        end
      end
      S_PAD2, S_PAD80: begin
        if (!r_out_valid) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Outputs: ready only when idle in FILL; block word straight from registers.
  always_comb begin
    bus.in_ready  = (r_state == S_FILL) && !r_out_valid;
    bus.out_valid = r_out_valid;
    bus.out       = {r_out_valid, r_start, r_stop, r_w};
  end

  // Block assembly: merge the beat at ptr, then build the padded tail variant.
  always_comb begin
    w_n    = bus.in_last ? bus.in_nbytes : '0;
    w_beat = bus.in_data;
    for (int j = 0; j < IN_BYTES; j++) begin
      if (bus.in_last && (j >= int'(w_n))) w_beat[8*IN_BYTES-1-8*j -: 8] = 8'h00;
    end
    w_merged = r_buf;
    w_merged[511-8*int'(r_ptr) -: 8*IN_BYTES] = w_beat;

    w_p       = {1'b0, r_ptr} + 7'(w_n);
    w_wrap    = ({1'b0, r_ptr} + 7'(IN_BYTES)) == 7'd64;
    w_len_nxt = r_len + (bus.in_last ? 61'(w_n) : 61'(IN_BYTES));

    // 0x80 at byte p, zeros after it; length only fits when p <= 55.
    w_tail = w_merged;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) == w_p)      w_tail[511-8*b -: 8] = 8'h80;
      else if (7'(b) > w_p)  w_tail[511-8*b -: 8] = 8'h00;
    end
    if (w_p <= 7'd55) w_tail[63:0] = {w_len_nxt, 3'b000};

    w_pad = {448'd0, r_len, 3'b000};
    if (r_state == S_PAD80) w_pad[511:504] = 8'h80;
  end

  // Datapath registers: buffer, pointer, length, first flag and output block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_w         <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_first     <= 1'b1;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

      if (w_acc) begin
        r_len <= w_len_nxt;
        if (!bus.in_last) begin
          r_ptr <= r_ptr + 6'(IN_BYTES);
          r_buf <= w_wrap ? '0 : w_merged;
          if (w_wrap) begin
            r_w         <= w_merged;
            r_start     <= r_first;
            r_stop      <= 1'b0;
            r_out_valid <= 1'b1;
            r_first     <= 1'b0;
          end
        end else begin
          r_buf       <= '0;
          r_ptr       <= '0;
          r_w         <= w_tail;
          r_start     <= r_first;
          r_out_valid <= 1'b1;
          if (w_p <= 7'd55) begin
            r_stop  <= 1'b1;
            r_len   <= '0;
            r_first <= 1'b1;
          end else begin
            // Length kept for the trailing pad block.
            r_stop  <= 1'b0;
            r_first <= 1'b0;
          end
        end
      end else if (w_pad_load) begin
        r_w         <= w_pad;
        r_start     <= 1'b0;
        r_stop      <= 1'b1;
        r_out_valid <= 1'b1;
        r_len       <= '0;
        r_first     <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_pad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_pad
//  Description : Directed self-checking bench for sha256_pad at IN_BYTES of
//                4, 1 and 16.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_sha256_pad;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sha256_pad_if #(.IN_BYTES(4))  ifc4 ();
  sha256_pad_if #(.IN_BYTES(1))  ifc1 ();
  sha256_pad_if #(.IN_BYTES(16)) ifc16 ();

  sha256_pad #(.IN_BYTES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(ifc4));
  sha256_pad #(.IN_BYTES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(ifc1));
  sha256_pad #(.IN_BYTES(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(ifc16));

  // Illegal byte count on a last beat is a stimulus error.
  always @(posedge clk) begin
    if (rst_n && ifc4.in_valid && ifc4.in_last)
      assert (ifc4.in_nbytes <= 3'd4) else $error("illegal in_nbytes");
  end

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 5 + 17);
  endfunction

  // Raw message bytes 0..L-1 placed MSB-first, rest zero.
  function automatic logic [511:0] exp_data(input int L);
    logic [511:0] e = '0;
    for (int i = 0; i < L; i++) e[511-8*i -: 8] = pat(i);
    return e;
  endfunction

  function automatic logic vld(input int w);
    case (w)
      1:       return ifc1.out_valid;
      16:      return ifc16.out_valid;
      default: return ifc4.out_valid;
    endcase
  endfunction

  function automatic logic [514:0] ob(input int w);
    case (w)
      1:       return ifc1.out;
      16:      return ifc16.out;
      default: return ifc4.out;
    endcase
  endfunction

  task automatic set_rdy(input int w, input logic v);
    case (w)
      1:       ifc1.out_ready = v;
      16:      ifc16.out_ready = v;
      default: ifc4.out_ready = v;
    endcase
  endtask

  // Wait (bounded) for a block, compare it, then consume it.
  task automatic get(input string tag, input int w, input logic st, input logic sp,
                     input logic [511:0] we);
    int t = 0;
    @(negedge clk);
    while (!vld(w) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 576'(ob(w)), 576'({1'b1, st, sp, we}));
    set_rdy(w, 1'b1);
    @(posedge clk);
    #1 set_rdy(w, 1'b0);
  endtask

  task automatic send4(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t = 0;
    @(negedge clk);
    while (!ifc4.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready", 576'(ifc4.in_ready), 576'(1'b1));
    ifc4.in_valid  = 1'b1;
    ifc4.in_data   = d;
    ifc4.in_last   = last;
    ifc4.in_nbytes = nb;
    @(posedge clk);
    #1 ifc4.in_valid = 1'b0;
  endtask

  task automatic send_msg4(input int L);
    int nbeats = (L == 0) ? 1 : (L + 3) / 4;
    for (int k = 0; k < nbeats; k++) begin
      logic [31:0] d = '0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < L) d[31-8*j -: 8] = pat(4*k + j);
      send4(d, k == nbeats - 1, 3'(L - 4*k));
    end
  endtask

  task automatic wait_valid4();
    int t = 0;
    @(negedge clk);
    while (!ifc4.out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
  endtask

  localparam logic [511:0] C_ABC   = {32'h61626380, 416'd0, 64'h18};
  localparam logic [511:0] C_EMPTY = {8'h80, 504'd0};
  localparam logic [511:0] C_PAD64 = {8'h80, 440'd0, 64'h200};

  initial begin
    logic [511:0] e;
    ifc4.in_valid = 0;  ifc4.in_data = '0;  ifc4.in_last = 0;  ifc4.in_nbytes = '0;  ifc4.out_ready = 0;
    ifc1.in_valid = 0;  ifc1.in_data = '0;  ifc1.in_last = 0;  ifc1.in_nbytes = '0;  ifc1.out_ready = 0;
    ifc16.in_valid = 0; ifc16.in_data = '0; ifc16.in_last = 0; ifc16.in_nbytes = '0; ifc16.out_ready = 0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_valid4", 576'(ifc4.out_valid), 576'(0));
    chk("rst_out4",   576'(ifc4.out),       576'(0));
    chk("rst_ready4", 576'(ifc4.in_ready),  576'(1));
    chk("rst_ready1", 576'(ifc1.in_ready),  576'(1));
    chk("rst_ready16",576'(ifc16.in_ready), 576'(1));
    rst_n = 1'b1;

    // "abc".
    send4(32'h61626300, 1'b1, 3'd3);
    get("abc", 4, 1'b1, 1'b1, C_ABC);

    // Empty message.
    send_msg4(0);
    get("empty", 4, 1'b1, 1'b1, C_EMPTY);

    // 55 bytes: 0x80 at byte 55, length fits.
    send_msg4(55);
    e = exp_data(55);
    e[511-8*55 -: 8] = 8'h80;
    e[63:0] = 64'h1B8;
    get("m55", 4, 1'b1, 1'b1, e);

    // 56 bytes: length spills into a second block.
    send_msg4(56);
    e = exp_data(56);
    e[511-8*56 -: 8] = 8'h80;
    get("m56_b1", 4, 1'b1, 1'b0, e);
    get("m56_b2", 4, 1'b0, 1'b1, {448'd0, 64'h1C0});

    // 64 bytes ending on the boundary.
    send_msg4(64);
    get("m64_b1", 4, 1'b1, 1'b0, exp_data(64));
    get("m64_b2", 4, 1'b0, 1'b1, C_PAD64);

    // 64 bytes as non-last beats, then an empty last beat.
    for (int k = 0; k < 16; k++) begin
      logic [31:0] d;
      for (int j = 0; j < 4; j++) d[31-8*j -: 8] = pat(4*k + j);
      send4(d, 1'b0, 3'd0);
    end
    get("wrap_b1", 4, 1'b1, 1'b0, exp_data(64));
    send4(32'h0, 1'b1, 3'd0);
    get("wrap_b2", 4, 1'b0, 1'b1, C_PAD64);

    // Backpressure: block held stable, no input accepted.
    send4(32'h61626300, 1'b1, 3'd3);
    wait_valid4();
    for (int i = 0; i < 10; i++) begin
      chk("bp_out",   576'(ifc4.out),      576'({1'b1, 1'b1, 1'b1, C_ABC}));
      chk("bp_ready", 576'(ifc4.in_ready), 576'(0));
      @(negedge clk);
    end
    get("bp_abc", 4, 1'b1, 1'b1, C_ABC);
    @(negedge clk);
    chk("bp_drop", 576'(ifc4.out_valid), 576'(0));

    // Reset mid-message: partial bytes discarded.
    for (int k = 0; k < 5; k++) send4(32'hDEADBEEF, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 576'(ifc4.out_valid), 576'(0));
    chk("mid_rst_ready", 576'(ifc4.in_ready),  576'(1));
    rst_n = 1'b1;
    send4(32'h61626300, 1'b1, 3'd3);
    get("post_rst_abc", 4, 1'b1, 1'b1, C_ABC);

    // Reset with a block pending: block dropped.
    send4(32'h61626300, 1'b1, 3'd3);
    wait_valid4();
    rst_n = 1'b0;
    #1;
    chk("pend_rst_valid", 576'(ifc4.out_valid), 576'(0));
    chk("pend_rst_out",   576'(ifc4.out),       576'(0));
    @(negedge clk);
    rst_n = 1'b1;
    send_msg4(0);
    get("post_rst_empty", 4, 1'b1, 1'b1, C_EMPTY);

    // 64 bytes at IN_BYTES=1.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("w1_ready", 576'(ifc1.in_ready), 576'(1));
      ifc1.in_valid  = 1'b1;
      ifc1.in_data   = pat(i);
      ifc1.in_last   = (i == 63);
      ifc1.in_nbytes = 1'b1;
      @(posedge clk);
      #1 ifc1.in_valid = 1'b0;
    end
    get("w1_b1", 1, 1'b1, 1'b0, exp_data(64));
    get("w1_b2", 1, 1'b0, 1'b1, C_PAD64);

    // 64 bytes at IN_BYTES=16.
    for (int k = 0; k < 4; k++) begin
      logic [127:0] d;
      for (int j = 0; j < 16; j++) d[127-8*j -: 8] = pat(16*k + j);
      @(negedge clk);
      chk("w16_ready", 576'(ifc16.in_ready), 576'(1));
      ifc16.in_valid  = 1'b1;
      ifc16.in_data   = d;
      ifc16.in_last   = (k == 3);
      ifc16.in_nbytes = 5'd16;
      @(posedge clk);
      #1 ifc16.in_valid = 1'b0;
    end
    get("w16_b1", 16, 1'b1, 1'b0, exp_data(64));
    get("w16_b2", 16, 1'b0, 1'b1, C_PAD64);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
